// File: rtl/cpu_monitor_sampler.sv
// Purpose : registers the CPU GP/STAT buses for the monitor controller and logs every
//           change as a timestamped {GP, STAT, time} entry in a show-ahead FIFO.
// Latency : CPU_GP/CPU_STAT -> GP/STAT one edge; change -> FIFO entry one edge later.
// Backpressure: POP drains the head; a push into a full FIFO without a pop is dropped
//           and counted in OVERFLOW_CNT (saturating).
// Ports   : CLK, RST (sync, active high), CPU_GP/CPU_STAT (monitored buses),
//           ENABLE (capture + timestamp run), CLEAR (flush), POP (consume head),
//           GP/STAT (live copies), OUT_VALID/OUT_GP/OUT_STAT/OUT_TIME (FIFO head),
//           COUNT (entries held), OVERFLOW_CNT (dropped events).
module cpu_monitor_sampler #(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 24
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [31:0]              CPU_GP,
    input  logic [3:0]               CPU_STAT,
    input  logic                     ENABLE,
    input  logic                     CLEAR,
    input  logic                     POP,
    output logic [31:0]              GP,
    output logic [3:0]               STAT,
    output logic                     OUT_VALID,
    output logic [31:0]              OUT_GP,
    output logic [3:0]               OUT_STAT,
    output logic [TS_WIDTH-1:0]      OUT_TIME,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic [15:0]              OVERFLOW_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0]         gp;
        logic [3:0]          stat;
        logic [TS_WIDTH-1:0] ts;
    } entry_t;

    // Stage-1 live registers and change-detect state
    logic [31:0]         r_gp;
    logic [3:0]          r_stat;
    logic [TS_WIDTH-1:0] r_ts;
    logic [31:0]         r_last_gp;
    logic [3:0]          r_last_stat;
    logic                r_first;

    // FIFO state; pointers carry one extra bit so full and empty are distinguishable
    entry_t              r_mem [DEPTH];
    logic [AW:0]         r_wptr;
    logic [AW:0]         r_rptr;
    entry_t              r_head;
    logic [15:0]         r_ovf;

    logic [AW:0]         w_count;
    logic                w_empty;
    logic                w_full;
    logic                w_event;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    entry_t              w_entry;
    logic [AW:0]         w_rptr_nxt;
    logic [AW:0]         w_remain;
    entry_t              w_head_nxt;

    assign w_count    = r_wptr - r_rptr;
    assign w_empty    = (w_count == '0);
    assign w_full     = (w_count == L_FULL);
    assign w_event    = ENABLE & (r_first | (r_gp != r_last_gp) | (r_stat != r_last_stat));
    assign w_pop      = POP & ~w_empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign w_push     = w_event & (~w_full | w_pop);
    assign w_drop     = w_event & w_full & ~w_pop;
    assign w_entry    = {r_gp, r_stat, r_ts};
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};
    assign w_remain   = w_count - {{AW{1'b0}}, w_pop};

    // The head register mirrors mem[rptr]. When nothing older than the pushed
    // entry remains, the new entry becomes the head directly (bypass); when the
    // FIFO drains, the head keeps its last value.
    always_comb begin
        w_head_nxt = r_head;
        if (w_remain == '0) begin
            if (w_push) begin
                w_head_nxt = w_entry;
            end
        end else begin
            w_head_nxt = r_mem[w_rptr_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_gp        <= '0;
            r_stat      <= '0;
            r_ts        <= '0;
            r_last_gp   <= '0;
            r_last_stat <= '0;
            r_first     <= 1'b1;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_head      <= '0;
            r_ovf       <= '0;
        end else begin
            r_gp   <= CPU_GP;
            r_stat <= CPU_STAT;
            if (CLEAR) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_ts    <= '0;
                r_ovf   <= '0;
                r_first <= 1'b1;
            end else begin
                if (ENABLE) begin
                    r_ts <= r_ts + TS_WIDTH'(1);
                end
                // Change tracking advances even when the entry is dropped,
                // so each transition is accounted for exactly once.
                if (w_event) begin
                    r_last_gp   <= r_gp;
                    r_last_stat <= r_stat;
                    r_first     <= 1'b0;
                end
                if (w_push) begin
                    r_wptr <= r_wptr + (AW+1)'(1);
                end
                r_rptr <= w_rptr_nxt;
                if (w_drop && (r_ovf != 16'hFFFF)) begin
                    r_ovf <= r_ovf + 16'd1;
                end
                r_head <= w_head_nxt;
            end
        end
    end

    // Storage array carries no reset; validity is defined by the pointers.
    always_ff @(posedge CLK) begin
        if (!RST && !CLEAR && w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_entry;
        end
    end

    assign GP           = r_gp;
    assign STAT         = r_stat;
    assign OUT_VALID    = ~w_empty;
    assign OUT_GP       = r_head.gp;
    assign OUT_STAT     = r_head.stat;
    assign OUT_TIME     = r_head.ts;
    assign COUNT        = w_count;
    assign OVERFLOW_CNT = r_ovf;

endmodule

// File: tb/tb_cpu_monitor_sampler.sv
// Purpose : self-checking bench for cpu_monitor_sampler (DEPTH=16, TS_WIDTH=4 so
//           timestamps wrap quickly). Directed scenarios followed by random traffic.
// Latency : reference model updates on each rising edge; monitor samples mid-low phase.
// Backpressure: POP driven by the stimulus; model tracks drops and overflow count.
module tb_cpu_monitor_sampler;

    localparam int DEPTH = 16;
    localparam int TSW   = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic [31:0]       CPU_GP;
    logic [3:0]        CPU_STAT;
    logic              ENABLE;
    logic              CLEAR;
    logic              POP;
    logic [31:0]       GP;
    logic [3:0]        STAT;
    logic              OUT_VALID;
    logic [31:0]       OUT_GP;
    logic [3:0]        OUT_STAT;
    logic [TSW-1:0]    OUT_TIME;
    logic [4:0]        COUNT;
    logic [15:0]       OVERFLOW_CNT;

    cpu_monitor_sampler #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .CLK(CLK), .RST(RST), .CPU_GP(CPU_GP), .CPU_STAT(CPU_STAT),
        .ENABLE(ENABLE), .CLEAR(CLEAR), .POP(POP),
        .GP(GP), .STAT(STAT), .OUT_VALID(OUT_VALID), .OUT_GP(OUT_GP),
        .OUT_STAT(OUT_STAT), .OUT_TIME(OUT_TIME), .COUNT(COUNT),
        .OVERFLOW_CNT(OVERFLOW_CNT)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] gp;
        logic [3:0]  stat;
        int          ts;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_gp, m_last_gp;
    logic [3:0]  m_stat, m_last_stat;
    int          m_ts, m_ovf;
    bit          m_first;
    bit          model_up = 0;

    initial begin
        forever begin
            @(posedge CLK);
            if (RST) begin
                mq.delete();
                m_gp = 0; m_stat = 0; m_ts = 0; m_ovf = 0; m_first = 1;
                m_last_gp = 0; m_last_stat = 0;
            end else begin
                bit ev;
                ev = ENABLE && (m_first || m_gp != m_last_gp || m_stat != m_last_stat);
                if (CLEAR) begin
                    mq.delete();
                    m_ts = 0; m_ovf = 0; m_first = 1;
                end else begin
                    if (POP && mq.size() > 0) void'(mq.pop_front());
                    if (ev) begin
                        m_last_gp = m_gp; m_last_stat = m_stat; m_first = 0;
                        if (mq.size() < DEPTH) mq.push_back('{m_gp, m_stat, m_ts});
                        else if (m_ovf < 65535) m_ovf++;
                    end
                    if (ENABLE) m_ts = (m_ts + 1) % (1 << TSW);
                end
                m_gp = CPU_GP; m_stat = CPU_STAT;
            end
            model_up = 1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge CLK);
            #3;
            if (model_up) begin
                chk("live_gp", 64'(GP), 64'(m_gp));
                chk("live_stat", 64'(STAT), 64'(m_stat));
                chk("count", 64'(COUNT), 64'(mq.size()));
                chk("out_valid", 64'(OUT_VALID), 64'(mq.size() != 0));
                chk("overflow", 64'(OVERFLOW_CNT), 64'(m_ovf));
                if (OUT_VALID && mq.size() > 0) begin
                    chk("head_gp", 64'(OUT_GP), 64'(mq[0].gp));
                    chk("head_stat", 64'(OUT_STAT), 64'(mq[0].stat));
                    chk("head_time", 64'(OUT_TIME), 64'(mq[0].ts));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    // Applies one cycle of inputs and returns at the following falling edge,
    // i.e. after the rising edge that consumed them.
    task automatic cyc(input bit r, input bit en, input logic [31:0] g,
                       input logic [3:0] s, input bit c, input bit p);
        RST = r; ENABLE = en; CPU_GP = g; CPU_STAT = s; CLEAR = c; POP = p;
        @(negedge CLK);
    endtask

    logic [31:0] g_last;
    logic [31:0] rg;
    logic [3:0]  rs;

    initial begin
        RST = 1; ENABLE = 0; CPU_GP = 0; CPU_STAT = 0; CLEAR = 0; POP = 0;
        @(negedge CLK);
        repeat (3) cyc(1, 1, 32'hDEADBEEF, 4'hA, 0, 0);
        chk("rst_gp", 64'(GP), 64'h0);
        chk("rst_count", 64'(COUNT), 64'h0);
        chk("rst_valid", 64'(OUT_VALID), 64'h0);
        chk("rst_ovf", 64'(OVERFLOW_CNT), 64'h0);
        chk("rst_time", 64'(OUT_TIME), 64'h0);

        // Constant zero input: exactly one initial entry
        repeat (2) cyc(0, 1, 32'h0, 4'h0, 0, 0);
        chk("first_count", 64'(COUNT), 64'h1);
        chk("first_time", 64'(OUT_TIME), 64'h0);
        chk("first_gp", 64'(OUT_GP), 64'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 32'h0, 4'h0, 0, 0);
            chk("first_hold_count", 64'(COUNT), 64'h1);
        end

        // Pop it, then a GP change registered with timestamp 10
        cyc(0, 1, 32'h0, 4'h0, 0, 1);
        repeat (2) cyc(0, 1, 32'h0, 4'h0, 0, 0);
        cyc(0, 1, 32'h12345678, 4'h0, 0, 0);
        chk("chg_live_gp", 64'(GP), 64'h12345678);
        chk("chg_not_yet", 64'(OUT_VALID), 64'h0);
        cyc(0, 1, 32'h12345678, 4'h0, 0, 0);
        chk("chg_valid", 64'(OUT_VALID), 64'h1);
        chk("chg_out_gp", 64'(OUT_GP), 64'h12345678);
        chk("chg_out_time", 64'(OUT_TIME), 64'd10);
        cyc(0, 1, 32'h12345678, 4'h0, 0, 1);

        // Clear, then toggle STAT for 20 cycles: 21 events, 16 kept, 5 dropped
        cyc(0, 1, 32'h12345678, 4'h0, 1, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 32'h12345678, (i % 2 == 0) ? 4'h1 : 4'h0, 0, 0);
        repeat (3) cyc(0, 1, 32'h12345678, 4'h0, 0, 0);
        chk("fill_count", 64'(COUNT), 64'd16);
        chk("fill_ovf", 64'(OVERFLOW_CNT), 64'd5);
        chk("fill_head_time", 64'(OUT_TIME), 64'h0);
        chk("fill_head_stat", 64'(OUT_STAT), 64'h0);

        // Full FIFO with continuous pops and changes every cycle: no drops
        cyc(0, 1, 32'h10000000, 4'h0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            g_last = 32'h10000001 + 32'(i);
            cyc(0, 1, g_last, 4'h0, 0, 1);
            chk("full_pop_count", 64'(COUNT), 64'd16);
            chk("full_pop_ovf", 64'(OVERFLOW_CNT), 64'd5);
        end

        // Drain to 7, then CLEAR together with POP
        for (int i = 0; i < 40 && mq.size() != 7; i++) cyc(0, 1, g_last, 4'h0, 0, 1);
        chk("pre_clear_count", 64'(COUNT), 64'd7);
        cyc(0, 1, g_last, 4'h0, 1, 1);
        chk("clear_count", 64'(COUNT), 64'h0);
        chk("clear_ovf", 64'(OVERFLOW_CNT), 64'h0);
        chk("clear_valid", 64'(OUT_VALID), 64'h0);
        cyc(0, 1, g_last, 4'h0, 0, 0);
        chk("post_clear_valid", 64'(OUT_VALID), 64'h1);
        chk("post_clear_count", 64'(COUNT), 64'h1);
        chk("post_clear_time", 64'(OUT_TIME), 64'h0);
        chk("post_clear_gp", 64'(OUT_GP), 64'(g_last));

        // ENABLE low: pops honoured, changes not logged until re-enabled
        repeat (3) cyc(0, 0, 32'hCAFE0001, 4'h3, 0, 1);
        chk("dis_count", 64'(COUNT), 64'h0);
        cyc(0, 1, 32'hCAFE0001, 4'h3, 0, 0);
        chk("reen_count", 64'(COUNT), 64'h1);
        chk("reen_gp", 64'(OUT_GP), 64'hCAFE0001);
        chk("reen_stat", 64'(OUT_STAT), 64'h3);
        cyc(0, 0, 32'hCAFE0001, 4'h3, 0, 1);
        cyc(0, 1, 32'hCAFE0001, 4'h3, 0, 0);
        chk("reen_nochg_count", 64'(COUNT), 64'h0);

        // Random traffic including occasional CLEAR and mid-run reset
        rg = 32'hCAFE0001; rs = 4'h3;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) rg = 32'hA5000000 | 32'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rs = 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 4) != 0), rg, rs,
                ($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0));
        end
        repeat (2) cyc(0, 1, rg, rs, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/cpu_monitor_sampler.md
Name: cpu_monitor_sampler

Overview:
Upstream feeder for the CPU monitor AXI controller. It registers the CPU's GP (32-bit) and STAT (4-bit) buses and presents the registered copies as live values to the controller's GP/STAT inputs. When a value changes, it logs a timestamped event into a small show-ahead FIFO. The controller drains that FIFO through a pop strobe, so software sees every transition, not just the latest value.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
TS_WIDTH, 24, timestamp counter width.

Ports:
CLK  in  1  system clock; all logic on rising edge.
RST  in  1  synchronous, active-high reset.
CPU_GP  in  32  CPU general-purpose monitor bus.
CPU_STAT  in  4  CPU status bus.
ENABLE  in  1  capture enable.
CLEAR  in  1  one-cycle pulse: flush FIFO, zero timestamp and overflow count.
POP  in  1  consume head entry.
GP  out  32  registered CPU_GP, to controller.
STAT  out  4  registered CPU_STAT, to controller.
OUT_VALID  out  1  FIFO non-empty.
OUT_GP  out  32  head entry GP.
OUT_STAT  out  4  head entry STAT.
OUT_TIME  out  TS_WIDTH  head entry timestamp.
COUNT  out  $clog2(DEPTH)+1  entries held.
OVERFLOW_CNT  out  16  dropped events, saturating.

Behaviour:
- Reset (RST=1 at edge): all outputs 0; FIFO empty; timestamp 0; "first" flag set.
- Stage 1:
  - Every cycle, GP<=CPU_GP and STAT<=CPU_STAT, regardless of ENABLE.
  - When ENABLE=1, the timestamp increments by 1 each cycle and wraps modulo 2^TS_WIDTH.
  - When ENABLE=0, the timestamp holds.
- Event detect, combinational on stage-1 regs: event = ENABLE & (first | GP!=last_gp | STAT!=last_stat).
  - The written timestamp is the stage-1 timestamp value in the cycle of detection.
- Push at the edge where event=1:
  - Entry {GP, STAT, ts} is written.
  - last_gp/last_stat update and first clears.
  - last_* and first update even if the entry is dropped, so each change is counted once.
- Latency:
  - A CPU_GP change present before edge k appears on GP after edge k.
  - That event is pushed at edge k+1.
  - If the FIFO was empty, OUT_VALID=1 after edge k+1.
- FIFO:
  - Show-ahead: OUT_* always reflect the head entry.
  - OUT_* hold their last value when empty; the checker ignores them while OUT_VALID=0.
- Pop:
  - POP with OUT_VALID=1 removes the head at the edge.
  - POP while empty is ignored, with no underflow.
- Push while full, no pop: the entry is dropped and OVERFLOW_CNT increments, saturating at 0xFFFF.
- Push and pop in the same cycle:
  - Both are performed and COUNT is unchanged.
  - This holds when full too: no drop.
  - When empty, only the push happens.
- Pointers: wrap modulo DEPTH. COUNT = write count - read count, range 0..DEPTH.
- CLEAR (priority below RST, above all else):
  - Pointers, COUNT, timestamp and OVERFLOW_CNT go to 0 and first is set.
  - A push or pop in the same cycle is discarded.
  - The GP/STAT live regs still update.
- ENABLE=0:
  - No pushes and timestamp frozen; pops still honoured.
  - first is not set, so re-enabling logs only actual changes relative to last_*.
- Reset mid-operation: immediate return to the reset state; no partial entries survive.
- Implementation: the storage array needs no reset; only pointers, counters and flags are reset.

Test Plan:
- Reset release, ENABLE=1, CPU_GP=0x0, STAT=0 constant:
  - exactly one entry {0,0,ts=0} after 2 edges;
  - COUNT stays 1 thereafter.
- After the first entry is popped, change CPU_GP to 0x12345678 at cycle 10 (timestamp 10 after stage 1):
  - GP=0x12345678 one edge later;
  - OUT_VALID one edge after that, with OUT_GP=0x12345678, OUT_TIME=10.
- Toggle CPU_STAT every cycle for 20 cycles, no POP, DEPTH=16:
  - COUNT=16 after fill;
  - OVERFLOW_CNT=5 (21 events including the initial one);
  - popping yields the 16 oldest entries in order.
- With FIFO full, hold POP=1 while changes continue every cycle:
  - COUNT stays 16, no overflow increments;
  - popped timestamps are consecutive.
- Assert CLEAR while COUNT=7 and POP=1 in the same cycle:
  - next cycle COUNT=0, OVERFLOW_CNT=0, timestamp=0;
  - following edge logs the current value as the first entry.
- Run with TS_WIDTH=4 for 20 cycles of changes: timestamps wrap 15→0 in the stored entries.
